// File: rtl/scoreboard_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : scoreboard_hazard_unit
//  Brief    : Scoreboard-based hazard and forwarding unit beside the ID stage.
//             Tracks in-flight register writes by age and result latency,
//             selects a bypass stage per source operand, raises load-use and
//             branch-operand stalls, and freezes the back end while the
//             multi-cycle unit is occupied.
//  Revision : 1.0  initial release
// ============================================================================
module scoreboard_hazard_unit #(
    parameter int NREG      = 32,
    parameter int DEPTH     = 4,
    parameter int MAX_LAT   = 3,
    parameter int BR_EXTRA  = 1,
    parameter int MC_CYCLES = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid,
    input  logic [$clog2(NREG)-1:0]        id_rs1,
    input  logic [$clog2(NREG)-1:0]        id_rs2,
    input  logic                           id_rs1_used,
    input  logic                           id_rs2_used,
    input  logic [$clog2(NREG)-1:0]        id_rd,
    input  logic                           id_rd_we,
    input  logic [$clog2(MAX_LAT+1)-1:0]   id_lat,
    input  logic                           id_branch,
    input  logic                           id_multi,
    input  logic                           flush,
    output logic [$clog2(DEPTH)-1:0]       rs1_src,
    output logic [$clog2(DEPTH)-1:0]       rs2_src,
    output logic                           pc_en,
    output logic                           if_id_en,
    output logic                           id_ex_clear,
    output logic                           ex_freeze
);

    localparam int c_RW = $clog2(NREG);
    localparam int c_AW = $clog2(DEPTH + 1);
    localparam int c_LW = $clog2(MAX_LAT + 1);
    localparam int c_SW = $clog2(DEPTH);
    localparam int c_CW = $clog2(MC_CYCLES + 1);
    // Wide enough to hold any age and any latency plus the branch surcharge.
    localparam int c_NW = $clog2(MAX_LAT + BR_EXTRA + DEPTH + 1) + 1;

    typedef enum logic [0:0] {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    logic [NREG-1:0] valid_q, valid_d;
    logic [c_AW-1:0] age_q [NREG];
    logic [c_AW-1:0] age_d [NREG];
    logic [c_LW-1:0] lat_q [NREG];
    logic [c_LW-1:0] lat_d [NREG];
    mc_state_t       mc_state_q, mc_state_d;
    logic [c_CW-1:0] cnt_q, cnt_d;

    logic [c_RW-1:0] w_rs    [2];
    logic [1:0]      w_used;
    logic [1:0]      w_hit;
    logic [1:0]      w_ready;
    logic [c_NW-1:0] w_need  [2];
    logic [c_SW-1:0] w_src   [2];
    logic            w_raw_stall;
    logic            w_frozen;
    logic            w_issue;

    assign w_rs[0]   = id_rs1;
    assign w_rs[1]   = id_rs2;
    assign w_used[0] = id_rs1_used;
    assign w_used[1] = id_rs2_used;

    // Per-operand lookup: a hit is ready once its age has reached the
    // result latency (plus the extra compare cycle for branches in ID).
    generate
        for (genvar g = 0; g < 2; g++) begin : g_opnd
            assign w_hit[g]   = w_used[g] && (w_rs[g] != '0) && valid_q[w_rs[g]];
            assign w_need[g]  = c_NW'(lat_q[w_rs[g]]) + (id_branch ? c_NW'(BR_EXTRA) : '0);
            assign w_ready[g] = c_NW'(age_q[w_rs[g]]) >= w_need[g];
            assign w_src[g]   = (w_hit[g] && w_ready[g]) ? c_SW'(age_q[w_rs[g]]) : '0;
        end
    endgenerate

    assign w_raw_stall = id_valid && (|(w_hit & ~w_ready));
    assign w_frozen    = (mc_state_q == MC_BUSY);
    assign w_issue     = !rst && !w_frozen && !flush && !w_raw_stall && id_valid;

    // Pipeline control: reset forces a free-running pipe, then freeze > flush > stall.
    always_comb begin
        rs1_src     = w_src[0];
        rs2_src     = w_src[1];
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_clear = 1'b0;
        ex_freeze   = 1'b0;
        if (rst) begin
            rs1_src = '0;
            rs2_src = '0;
        end else if (w_frozen) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_freeze = 1'b1;
        end else if (flush) begin
            id_ex_clear = 1'b1;
        end else if (w_raw_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_clear = 1'b1;
        end
    end

    // Scoreboard update: age every entry while the back end moves, retire at
    // DEPTH, and let a newly issued writer overwrite any older entry.
    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        lat_d   = lat_q;
        if (!w_frozen) begin
            for (int r = 1; r < NREG; r++) begin
                if (valid_q[r]) begin
                    if (age_q[r] >= c_AW'(DEPTH - 1)) begin
                        valid_d[r] = 1'b0;
                        age_d[r]   = c_AW'(DEPTH);
                    end else begin
                        age_d[r] = age_q[r] + 1'b1;
                    end
                end
            end
            if (w_issue && id_rd_we && (id_rd != '0)) begin
                valid_d[id_rd] = 1'b1;
                age_d[id_rd]   = c_AW'(1);
                lat_d[id_rd]   = id_lat;
            end
        end
    end

    // Multi-cycle unit occupancy: BUSY for MC_CYCLES-1 cycles after issue.
    always_comb begin
        mc_state_d = mc_state_q;
        cnt_d      = cnt_q;
        case (mc_state_q)
            MC_IDLE: begin
                if (w_issue && id_multi && (MC_CYCLES > 1)) begin
                    mc_state_d = MC_BUSY;
                    cnt_d      = c_CW'(MC_CYCLES - 1);
                end
            end
            MC_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == c_CW'(1)) begin
                    mc_state_d = MC_IDLE;
                end
            end
            default: begin
                mc_state_d = MC_IDLE;
                cnt_d      = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                age_q[r] <= '0;
                lat_q[r] <= '0;
            end
            mc_state_q <= MC_IDLE;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            age_q      <= age_d;
            lat_q      <= lat_d;
            mc_state_q <= mc_state_d;
            cnt_q      <= cnt_d;
        end
    end

    // Writers must declare a result latency the scoreboard can represent.
    a_lat_legal : assert property (@(posedge clk) disable iff (rst)
        (id_valid && id_rd_we) |-> ((id_lat != '0) && (id_lat <= c_LW'(MAX_LAT))));

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scoreboard_hazard_unit
//  Brief    : Self-checking bench for scoreboard_hazard_unit: directed
//             scenarios plus randomized traffic against a queue-based model
//             of in-flight writes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scoreboard_hazard_unit;

    localparam int NREG      = 32;
    localparam int DEPTH     = 4;
    localparam int MAX_LAT   = 3;
    localparam int BR_EXTRA  = 1;
    localparam int MC_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_rd_we;
    logic [1:0] id_lat;
    logic       id_branch, id_multi, flush;
    logic [1:0] rs1_src, rs2_src;
    logic       pc_en, if_id_en, id_ex_clear, ex_freeze;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scoreboard_hazard_unit #(
        .NREG(NREG), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT),
        .BR_EXTRA(BR_EXTRA), .MC_CYCLES(MC_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_lat(id_lat),
        .id_branch(id_branch), .id_multi(id_multi), .flush(flush),
        .rs1_src(rs1_src), .rs2_src(rs2_src), .pc_en(pc_en),
        .if_id_en(if_id_en), .id_ex_clear(id_ex_clear), .ex_freeze(ex_freeze)
    );

    // Reference model: list of in-flight writes, youngest first.
    typedef struct {
        int rd;
        int lat;
        int age;
    } wr_t;
    wr_t inflight[$];
    int  frz_left = 0;

    function automatic void m_lookup(input int rs, input bit used, output int src, output bit stall);
        bit found;
        int need;
        src   = 0;
        stall = 1'b0;
        found = 1'b0;
        if (used && rs != 0) begin
            foreach (inflight[i]) begin
                if (!found && inflight[i].rd == rs) begin
                    found = 1'b1;
                    need  = inflight[i].lat + (id_branch ? BR_EXTRA : 0);
                    if (inflight[i].age >= need) src = inflight[i].age;
                    else stall = 1'b1;
                end
            end
        end
    endfunction

    function automatic void m_eval(output int e1, output int e2, output bit pc, output bit ifd,
                                   output bit clr, output bit frz, output bit iss);
        bit s1, s2;
        m_lookup(int'(id_rs1), id_rs1_used, e1, s1);
        m_lookup(int'(id_rs2), id_rs2_used, e2, s2);
        pc = 1'b1; ifd = 1'b1; clr = 1'b0; frz = 1'b0; iss = 1'b0;
        if (rst) begin
            e1 = 0; e2 = 0;
        end else if (frz_left > 0) begin
            pc = 1'b0; ifd = 1'b0; frz = 1'b1;
        end else if (flush) begin
            clr = 1'b1;
        end else if (id_valid && (s1 || s2)) begin
            pc = 1'b0; ifd = 1'b0; clr = 1'b1;
        end else begin
            iss = id_valid;
        end
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        int  e1, e2;
        bit  pc, ifd, clr, frz, iss;
        wr_t w;
        m_eval(e1, e2, pc, ifd, clr, frz, iss);
        @(posedge clk);
        if (rst) begin
            inflight.delete();
            frz_left = 0;
        end else if (frz_left > 0) begin
            frz_left--;
        end else begin
            for (int i = inflight.size() - 1; i >= 0; i--) begin
                inflight[i].age++;
                if (inflight[i].age >= DEPTH) inflight.delete(i);
            end
            if (iss && id_rd_we && id_rd != 0) begin
                w.rd = int'(id_rd); w.lat = int'(id_lat); w.age = 1;
                inflight.push_front(w);
            end
            if (iss && id_multi && MC_CYCLES > 1) frz_left = MC_CYCLES - 1;
        end
        #1;
    endtask

    task automatic set_instr(input bit v, input int a1, input bit u1, input int a2, input bit u2,
                             input int rd, input bit we, input int lat, input bit br, input bit mul);
        id_valid = v;   id_rs1 = 5'(a1); id_rs1_used = u1; id_rs2 = 5'(a2); id_rs2_used = u2;
        id_rd = 5'(rd); id_rd_we = we;   id_lat = 2'(lat); id_branch = br;  id_multi = mul;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_instr(1, 3, 1, 4, 1, 0, 0, 1, 1, 0);
        @(negedge clk);
        checks++; if (pc_en !== 1'b1)       begin failures++; $display("FAIL reset pc_en got=%b exp=1", pc_en); end
        checks++; if (if_id_en !== 1'b1)    begin failures++; $display("FAIL reset if_id_en got=%b exp=1", if_id_en); end
        checks++; if (id_ex_clear !== 1'b0) begin failures++; $display("FAIL reset id_ex_clear got=%b exp=0", id_ex_clear); end
        checks++; if (ex_freeze !== 1'b0)   begin failures++; $display("FAIL reset ex_freeze got=%b exp=0", ex_freeze); end
        checks++; if (rs1_src !== 2'd0)     begin failures++; $display("FAIL reset rs1_src got=%0d exp=0", rs1_src); end
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rs1_src !== 2'd0 || rs2_src !== 2'd0) begin failures++; $display("FAIL post_reset src got=%0d/%0d exp=0/0", rs1_src, rs2_src); end
        checks++; if (pc_en !== 1'b1)       begin failures++; $display("FAIL post_reset pc_en got=%b exp=1", pc_en); end
        tick();
    endtask

    task automatic test_alu_forward();
        do_reset();
        set_instr(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); @(negedge clk); tick();
        set_instr(1, 5, 1, 0, 0, 0, 0, 1, 0, 0); @(negedge clk);
        checks++; if (pc_en !== 1'b1 || id_ex_clear !== 1'b0) begin failures++; $display("FAIL alu_t1 stall got pc_en=%b clr=%b exp 1/0", pc_en, id_ex_clear); end
        checks++; if (rs1_src !== 2'd1) begin failures++; $display("FAIL alu_t1 rs1_src got=%0d exp=1", rs1_src); end
        tick(); @(negedge clk);
        checks++; if (rs1_src !== 2'd2) begin failures++; $display("FAIL alu_t2 rs1_src got=%0d exp=2", rs1_src); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_instr(1, 0, 0, 0, 0, 6, 1, 2, 0, 0); @(negedge clk); tick();
        set_instr(1, 0, 0, 6, 1, 0, 0, 1, 0, 0); @(negedge clk);
        checks++; if (pc_en !== 1'b0 || if_id_en !== 1'b0 || id_ex_clear !== 1'b1) begin failures++; $display("FAIL load_use_t1 got pc=%b ifid=%b clr=%b exp 0/0/1", pc_en, if_id_en, id_ex_clear); end
        tick(); @(negedge clk);
        checks++; if (rs2_src !== 2'd2) begin failures++; $display("FAIL load_use_t2 rs2_src got=%0d exp=2", rs2_src); end
        checks++; if (pc_en !== 1'b1 || id_ex_clear !== 1'b0) begin failures++; $display("FAIL load_use_t2 ctrl got pc=%b clr=%b exp 1/0", pc_en, id_ex_clear); end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        set_instr(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); @(negedge clk); tick();
        set_instr(1, 7, 1, 0, 0, 0, 0, 1, 1, 0); @(negedge clk);
        checks++; if (pc_en !== 1'b0 || id_ex_clear !== 1'b1) begin failures++; $display("FAIL branch_t1 got pc=%b clr=%b exp 0/1", pc_en, id_ex_clear); end
        tick(); @(negedge clk);
        checks++; if (rs1_src !== 2'd2 || pc_en !== 1'b1) begin failures++; $display("FAIL branch_t2 got src=%0d pc=%b exp 2/1", rs1_src, pc_en); end
        tick(); @(negedge clk);
        checks++; if (rs1_src !== 2'd3) begin failures++; $display("FAIL branch_t3 rs1_src got=%0d exp=3", rs1_src); end
        tick(); @(negedge clk);
        checks++; if (rs1_src !== 2'd0 || pc_en !== 1'b1) begin failures++; $display("FAIL branch_t4 got src=%0d pc=%b exp 0/1", rs1_src, pc_en); end
        tick();
    endtask

    task automatic test_multicycle();
        do_reset();
        set_instr(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); @(negedge clk); tick();
        set_instr(1, 0, 0, 0, 0, 10, 1, 1, 0, 1); @(negedge clk);
        checks++; if (ex_freeze !== 1'b0) begin failures++; $display("FAIL mc_issue ex_freeze got=%b exp=0", ex_freeze); end
        tick();
        for (int k = 1; k < MC_CYCLES; k++) begin
            set_instr(1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
            flush = (k == 3);
            @(negedge clk);
            checks++; if (ex_freeze !== 1'b1) begin failures++; $display("FAIL mc_freeze k=%0d ex_freeze got=%b exp=1", k, ex_freeze); end
            checks++; if (pc_en !== 1'b0 || if_id_en !== 1'b0 || id_ex_clear !== 1'b0) begin failures++; $display("FAIL mc_ctrl k=%0d got pc=%b ifid=%b clr=%b exp 0/0/0", k, pc_en, if_id_en, id_ex_clear); end
            checks++; if (rs1_src !== 2'd2) begin failures++; $display("FAIL mc_age_hold k=%0d rs1_src got=%0d exp=2", k, rs1_src); end
            tick();
        end
        set_instr(1, 5, 1, 0, 0, 0, 0, 1, 0, 0); @(negedge clk);
        checks++; if (ex_freeze !== 1'b0 || pc_en !== 1'b1) begin failures++; $display("FAIL mc_end got frz=%b pc=%b exp 0/1", ex_freeze, pc_en); end
        checks++; if (rs1_src !== 2'd2) begin failures++; $display("FAIL mc_end rs1_src got=%0d exp=2", rs1_src); end
        tick();
    endtask

    task automatic test_youngest_writer();
        do_reset();
        set_instr(1, 0, 0, 0, 0, 9, 1, 1, 0, 0); @(negedge clk); tick();
        set_instr(1, 0, 0, 0, 0, 9, 1, 1, 0, 0); @(negedge clk); tick();
        set_instr(1, 9, 1, 9, 1, 0, 0, 1, 0, 0); @(negedge clk);
        checks++; if (rs1_src !== 2'd1 || rs2_src !== 2'd1) begin failures++; $display("FAIL youngest src got=%0d/%0d exp=1/1", rs1_src, rs2_src); end
        tick();
        set_instr(1, 0, 0, 0, 0, 0, 1, 3, 0, 0); @(negedge clk); tick();
        set_instr(1, 0, 1, 0, 1, 0, 0, 1, 1, 0); @(negedge clk);
        checks++; if (pc_en !== 1'b1 || id_ex_clear !== 1'b0) begin failures++; $display("FAIL rd0 stall got pc=%b clr=%b exp 1/0", pc_en, id_ex_clear); end
        checks++; if (rs1_src !== 2'd0 || rs2_src !== 2'd0) begin failures++; $display("FAIL rd0 src got=%0d/%0d exp=0/0", rs1_src, rs2_src); end
        tick();
    endtask

    task automatic test_reset_mid_freeze();
        do_reset();
        set_instr(1, 0, 0, 0, 0, 5, 1, 3, 0, 0); @(negedge clk); tick();
        set_instr(1, 0, 0, 0, 0, 10, 1, 3, 0, 1); @(negedge clk); tick();
        set_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); @(negedge clk); tick();
        @(negedge clk);
        checks++; if (ex_freeze !== 1'b1) begin failures++; $display("FAIL rst_mid t2 ex_freeze got=%b exp=1", ex_freeze); end
        tick();
        rst = 1'b1; @(negedge clk);
        checks++; if (ex_freeze !== 1'b0 || pc_en !== 1'b1) begin failures++; $display("FAIL rst_mid t3 got frz=%b pc=%b exp 0/1", ex_freeze, pc_en); end
        tick();
        rst = 1'b0;
        set_instr(1, 5, 1, 10, 1, 0, 0, 1, 1, 0); @(negedge clk);
        checks++; if (ex_freeze !== 1'b0) begin failures++; $display("FAIL rst_mid t4 ex_freeze got=%b exp=0", ex_freeze); end
        checks++; if (rs1_src !== 2'd0 || rs2_src !== 2'd0) begin failures++; $display("FAIL rst_mid t4 src got=%0d/%0d exp=0/0", rs1_src, rs2_src); end
        checks++; if (pc_en !== 1'b1 || id_ex_clear !== 1'b0) begin failures++; $display("FAIL rst_mid t4 stall got pc=%b clr=%b exp 1/0", pc_en, id_ex_clear); end
        tick();
    endtask

    task automatic test_random();
        int e1, e2;
        bit pc, ifd, clr, frz, iss;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            id_rd       = 5'($urandom_range(0, 7));
            id_rd_we    = ($urandom_range(0, 3) != 0);
            id_lat      = 2'($urandom_range(1, MAX_LAT));
            id_branch   = ($urandom_range(0, 3) == 0);
            id_multi    = ($urandom_range(0, 19) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            m_eval(e1, e2, pc, ifd, clr, frz, iss);
            checks++; if (int'(rs1_src) !== e1) begin failures++; $display("FAIL rand n=%0d rs1_src got=%0d exp=%0d", n, rs1_src, e1); end
            checks++; if (int'(rs2_src) !== e2) begin failures++; $display("FAIL rand n=%0d rs2_src got=%0d exp=%0d", n, rs2_src, e2); end
            checks++; if (pc_en !== pc)         begin failures++; $display("FAIL rand n=%0d pc_en got=%b exp=%b", n, pc_en, pc); end
            checks++; if (if_id_en !== ifd)     begin failures++; $display("FAIL rand n=%0d if_id_en got=%b exp=%b", n, if_id_en, ifd); end
            checks++; if (id_ex_clear !== clr)  begin failures++; $display("FAIL rand n=%0d id_ex_clear got=%b exp=%b", n, id_ex_clear, clr); end
            checks++; if (ex_freeze !== frz)    begin failures++; $display("FAIL rand n=%0d ex_freeze got=%b exp=%b", n, ex_freeze, frz); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        #1;
        test_reset();
        test_alu_forward();
        test_load_use();
        test_branch();
        test_multicycle();
        test_youngest_writer();
        test_reset_mid_freeze();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
